// File: rtl/wasm_exec.sv
// wasm_exec: multi-cycle WebAssembly i32-subset interpreter fetching bytecode over a byte-wide memory bus.
// Latency: each bus byte takes at least 3 cycles (request, ready edge, ready-low wait); DECODE and EXEC take 1 cycle each.
// Backpressure: every bus request is held until memory_ready=1, then the next waits for memory_ready=0.
// Ports: clk/rst (async, active-high); addr/data_in/data_out/memory_read_en/memory_write_en/memory_ready
//        form the shared bus; halted/trap/trap_code give the sticky final status; sp is the live stack depth.
// Optional feature: define WASM_EXEC_MUL_EN to build the single-cycle i32.mul (0x6C) datapath.
module wasm_exec #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                STACK_DEPTH   = 16,
  parameter logic [ADDR_W-1:0] CODE_PTR_ADDR = 'h30,
  parameter logic [ADDR_W-1:0] PC_RESET      = 'h1A,
  parameter logic [ADDR_W-1:0] RESULT_ADDR   = 'h40
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [ADDR_W-1:0]                addr,
  output logic [7:0]                       data_in,
  input  logic [7:0]                       data_out,
  output logic                             memory_read_en,
  output logic                             memory_write_en,
  input  logic                             memory_ready,
  output logic                             halted,
  output logic                             trap,
  output logic [2:0]                       trap_code,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp
);

  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;
  localparam int NB   = DATA_W / 8;
  localparam int MAXB = (DATA_W + 6) / 7;

  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  localparam logic [7:0] OP_CONST = 8'h41;
  localparam logic [7:0] OP_ADD   = 8'h6A;
  localparam logic [7:0] OP_SUB   = 8'h6B;
  localparam logic [7:0] OP_MUL   = 8'h6C;
  localparam logic [7:0] OP_DROP  = 8'h1A;
  localparam logic [7:0] OP_NOP   = 8'h01;
  localparam logic [7:0] OP_END   = 8'h0B;

  localparam logic [2:0] TRAP_NONE = 3'd0;
  localparam logic [2:0] TRAP_OVF  = 3'd1;
  localparam logic [2:0] TRAP_UNF  = 3'd2;
  localparam logic [2:0] TRAP_ILL  = 3'd3;
  localparam logic [2:0] TRAP_LEB  = 3'd4;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_STORE, S_HALT, S_TRAP
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   code_at;
  logic [7:0]          opcode;
  logic [7:0]          rd_byte;
  logic [DATA_W-1:0]   imm;
  logic [3:0]          leb_k;
  logic [3:0]          byte_idx;
  logic [DATA_W-1:0]   res_sh;
  logic                wait_low;
  logic [DATA_W-1:0]   stk [STACK_DEPTH];

  logic                bus_busy;
  logic                bus_idle;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   imm_next;
  logic [IDXW-1:0]     i_top, i_nxt, i_push;
  logic [DATA_W-1:0]   tos, op_a, bin_res;
  logic [2:0]          ex_code;
  logic [SPW-1:0]      ex_sp;
  logic                ex_store;
  logic                stk_we;
  logic [IDXW-1:0]     stk_widx;
  logic [DATA_W-1:0]   stk_wdat;

  assign bus_busy = memory_read_en | memory_write_en;
  assign bus_idle = ~bus_busy & ~wait_low;

  // Stack grows upward: entry sp-1 is the top, sp-2 the one beneath.
  assign i_top  = IDXW'(sp - SPW'(1));
  assign i_nxt  = IDXW'(sp - SPW'(2));
  assign i_push = IDXW'(sp);
  assign tos    = stk[i_top];
  assign op_a   = stk[i_nxt];

  always_comb begin
    case (state)
      S_BOOT:  req_addr = CODE_PTR_ADDR;
      S_STORE: req_addr = RESULT_ADDR + ADDR_W'(byte_idx);
      default: req_addr = code_at + pc;
    endcase
  end

  // Signed LEB128 accumulation of the byte just read; sign-extends on the
  // final byte only when the encoded bits do not already fill DATA_W.
  always_comb begin
    imm_next = imm | (DATA_W'(rd_byte[6:0]) << (7 * int'(leb_k)));
    if (!rd_byte[7] && rd_byte[6] && (7 * (int'(leb_k) + 1) < DATA_W))
      imm_next = imm_next | ({DATA_W{1'b1}} << (7 * (int'(leb_k) + 1)));
  end

  always_comb begin
    case (opcode)
      OP_SUB:  bin_res = op_a - tos;
`ifdef WASM_EXEC_MUL_EN
      OP_MUL:  bin_res = op_a * tos;
`endif
      default: bin_res = op_a + tos;
    endcase
  end

  // Fault checks precede any stack update, so a trapping instruction leaves
  // both the stack contents and sp untouched.
  always_comb begin
    ex_code  = TRAP_NONE;
    ex_sp    = sp;
    ex_store = 1'b0;
    stk_we   = 1'b0;
    stk_widx = i_push;
    stk_wdat = imm;
    case (opcode)
      OP_CONST: begin
        if (sp == SP_FULL) ex_code = TRAP_OVF;
        else begin
          ex_sp  = sp + SPW'(1);
          stk_we = 1'b1;
        end
      end
      OP_ADD, OP_SUB: begin
        if (sp < SPW'(2)) ex_code = TRAP_UNF;
        else begin
          ex_sp    = sp - SPW'(1);
          stk_we   = 1'b1;
          stk_widx = i_nxt;
          stk_wdat = bin_res;
        end
      end
`ifdef WASM_EXEC_MUL_EN
      OP_MUL: begin
        if (sp < SPW'(2)) ex_code = TRAP_UNF;
        else begin
          ex_sp    = sp - SPW'(1);
          stk_we   = 1'b1;
          stk_widx = i_nxt;
          stk_wdat = bin_res;
        end
      end
`endif
      OP_DROP: begin
        if (sp == '0) ex_code = TRAP_UNF;
        else ex_sp = sp - SPW'(1);
      end
      OP_NOP: ;
      OP_END: begin
        if (sp == '0) ex_code = TRAP_UNF;
        else ex_store = 1'b1;
      end
      default: ex_code = TRAP_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_EXEC && stk_we) stk[stk_widx] <= stk_wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_BOOT;
      pc              <= PC_RESET;
      code_at         <= '0;
      opcode          <= '0;
      rd_byte         <= '0;
      imm             <= '0;
      leb_k           <= '0;
      byte_idx        <= '0;
      res_sh          <= '0;
      wait_low        <= 1'b0;
      sp              <= '0;
      addr            <= '0;
      data_in         <= '0;
      memory_read_en  <= 1'b0;
      memory_write_en <= 1'b0;
      halted          <= 1'b0;
      trap            <= 1'b0;
      trap_code       <= '0;
    end else begin
      case (state)
        S_BOOT, S_FETCH, S_IMM, S_STORE: begin
          if (bus_idle) begin
            addr <= req_addr;
            if (state == S_STORE) begin
              memory_write_en <= 1'b1;
              data_in         <= res_sh[7:0];
            end else begin
              memory_read_en  <= 1'b1;
            end
          end else if (bus_busy && memory_ready) begin
            rd_byte         <= data_out;
            memory_read_en  <= 1'b0;
            memory_write_en <= 1'b0;
            wait_low        <= 1'b1;
          end else if (wait_low && !memory_ready) begin
            // Byte fully retired; act on it.
            wait_low <= 1'b0;
            case (state)
              S_BOOT: begin
                code_at <= ADDR_W'(rd_byte);
                state   <= S_FETCH;
              end
              S_FETCH: begin
                opcode <= rd_byte;
                pc     <= pc + ADDR_W'(1);
                state  <= S_DECODE;
              end
              S_IMM: begin
                imm <= imm_next;
                pc  <= pc + ADDR_W'(1);
                if (rd_byte[7]) begin
                  if (leb_k == 4'(MAXB - 1)) begin
                    state     <= S_TRAP;
                    trap      <= 1'b1;
                    trap_code <= TRAP_LEB;
                  end else begin
                    leb_k <= leb_k + 4'd1;
                  end
                end else begin
                  state <= S_EXEC;
                end
              end
              default: begin
                res_sh <= res_sh >> 8;
                if (byte_idx == 4'(NB - 1)) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                end else begin
                  byte_idx <= byte_idx + 4'd1;
                end
              end
            endcase
          end
        end
        S_DECODE: begin
          if (opcode == OP_CONST) begin
            imm   <= '0;
            leb_k <= '0;
            state <= S_IMM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_code != TRAP_NONE) begin
            state     <= S_TRAP;
            trap      <= 1'b1;
            trap_code <= ex_code;
          end else begin
            sp <= ex_sp;
            if (ex_store) begin
              res_sh   <= tos;
              byte_idx <= '0;
              state    <= S_STORE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: ;  // HALT and TRAP hold until reset
      endcase
    end
  end

endmodule

// File: doc/wasm_exec.md
# wasm_exec

Multi-cycle interpreter for a WebAssembly i32 subset, parametrised in data width and operand-stack depth. It fetches bytecode one byte at a time over the shared byte-wide memory bus, using the same read/write-enable plus `memory_ready` handshake as the existing core. The operand stack is held in internal registers, so only code fetch and the final result store use the bus. On `end` it writes the top of stack little-endian to a result address and halts. On any fault it traps.

## Interface
Parameters:
- `DATA_W`, 32: operand width in bits; a multiple of 8, from 8 to 64.
- `ADDR_W`, 32: bus address width.
- `STACK_DEPTH`, 16: number of operand-stack entries; minimum 2.
- `CODE_PTR_ADDR`, 'h30: address of the byte that holds the code base.
- `PC_RESET`, 'h1A: initial pc, as an offset from the code base.
- `RESULT_ADDR`, 'h40: first byte of the result store.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset; asynchronous, active-high.
- `addr`  out  ADDR_W: bus address.
- `data_in`  out  8: write data to memory.
- `data_out`  in  8: read data from memory.
- `memory_read_en`  out  1: read request.
- `memory_write_en`  out  1: write request.
- `memory_ready`  in  1: memory acknowledge.
- `halted`  out  1: sticky; set after a clean `end`.
- `trap`  out  1: sticky; set on a fault.
- `trap_code`  out  3: 1 = overflow, 2 = underflow, 3 = illegal opcode, 4 = LEB128 too long.
- `sp`  out  $clog2(STACK_DEPTH+1): current stack depth.

## Operation
- States: BOOT, FETCH, DECODE, IMM, EXEC, STORE, HALT, TRAP.
- Bus handshake, used for every read and write:
  - Drive `addr` and the enable, and hold them stable until `memory_ready`=1.
  - On that edge, latch `data_out` (reads) and drop the enable.
  - Wait for `memory_ready`=0 before issuing the next request.
- BOOT: read `CODE_PTR_ADDR`. The byte, zero-extended, becomes `code_at`. Go to FETCH.
- FETCH: read `code_at+pc`, then pc+1. Go to DECODE.
- DECODE:
  - 0x41 `i32.const`: go to IMM.
  - All other opcodes: go to EXEC.
- IMM: signed LEB128 decode, with pc+1 per byte.
  - Byte k contributes `(b&0x7F)<<7k`.
  - Continue while bit7 is set.
  - On the last byte, if bit6 is set and 7(k+1)<DATA_W, sign-extend.
  - More than ceil(DATA_W/7) bytes: trap code 4.
- EXEC, one cycle:
  - 0x41: push the immediate.
  - 0x6A `add`: pop b, pop a, push a+b.
  - 0x6B `sub`: pop b, pop a, push a−b.
  - 0x6C `mul`: pop b, pop a, push a×b (see Configuration).
  - 0x1A `drop`: pop.
  - 0x01 `nop`: no stack change.
  - 0x0B `end`: go to STORE.
  - Any other opcode: trap code 3.
  - All arithmetic wraps modulo 2^DATA_W and keeps the low DATA_W bits.
- Stack faults are checked before any state changes. On a fault the stack is untouched.
  - Push when sp==STACK_DEPTH: trap code 1.
  - Binary op with sp<2, drop with sp==0, or `end` with sp==0: trap code 2.
- STORE: write DATA_W/8 bytes of the top of stack, LSB first, to `RESULT_ADDR+i`. Each byte uses the full handshake. Then go to HALT.
- HALT and TRAP are absorbing until `rst`. Bus enables stay 0.

## Timing
- Reset values:
  - All outputs are 0 and `addr`=0.
  - Internally: pc=`PC_RESET`, sp=0, `code_at`=0, state BOOT.
- Reset mid-transaction drops both enables asynchronously. No partial store completes.
- One bus byte costs a minimum of 3 cycles: request, `ready` edge, `ready`-low wait.
- DECODE and EXEC take 1 cycle each. A register-only instruction (add, sub, mul, drop, nop) therefore takes fetch + 2 cycles.
- `memory_read_en` and `memory_write_en` are never both 1.
- `halted` and `trap` are never both 1.
- `trap` rises on the EXEC or IMM edge that detects the fault.
- `sp` updates on the EXEC edge.

## Configuration
- `WASM_EXEC_MUL_EN`:
  - Defined: 0x6C is implemented as a DATA_W×DATA_W multiply, truncated to DATA_W bits, single-cycle.
  - Undefined: no multiplier is built, and 0x6C traps with code 3 without popping.

## Test plan
- Code base 0x00; program at 0x1A: 41 05 41 07 6A 0B → bytes 0C 00 00 00 written to 0x40–0x43; `halted`=1, sp=1.
- Program 41 7F 41 02 6B 0B → −1−2 = FFFFFFFD; bytes FD FF FF FF stored.
- Program 6A with sp=0 → `trap`=1, code 2, no bus write; the same happens with `drop` first.
- STACK_DEPTH=4, five `i32.const` ops → trap code 1 on the fifth; sp stays 4.
- Program 41 03 41 04 6C 0B → with the macro, 0C stored; without it, trap code 3 and sp=2.
- Hold `memory_ready` low 10 cycles into a fetch, then assert `rst` → `memory_read_en`=0 immediately; after release the core re-runs BOOT and the program completes correctly.
